// File: rtl/alu_operand_loader_if.sv
// Operand-loader bus: upstream valid/ready word handshake plus the A/B/en outputs
// that feed the downstream ALU operand-enable gate.
interface alu_operand_loader_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en;

    // Master supplies words and consumes the operand pair; slave is the loader.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  a,
        input  b,
        input  en
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output a,
        output b,
        output en
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Captures two handshaked words as A then B and issues the pair with en high for HOLD cycles.
// Optional LOAD_B abort timer enabled by defining ALU_OPERAND_LOADER_TIMEOUT_EN.
module alu_operand_loader #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    alu_operand_loader_if.slave  bus,
    output logic                 o_busy,
    output logic [3:0]           o_pair_count,
    output logic                 o_timeout_err
);

`ifdef ALU_OPERAND_LOADER_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    localparam logic [3:0] HoldLast = 4'(HOLD - 1);
    localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StLoadA = 2'd0,
        StLoadB = 2'd1,
        StIssue = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_hold;
    logic [3:0]       r_pair_count;
    logic [7:0]       r_tmo;
    logic             r_timeout_err;
    logic             w_ready;
    logic             w_xfer;
    logic             w_tmo_expire;

    // Outputs decode registered state only, so en cannot glitch on input activity.
    assign w_ready       = (r_state != StIssue);
    assign w_xfer        = bus.in_valid && w_ready;
    assign bus.in_ready  = w_ready;
    assign bus.en        = (r_state == StIssue);
    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign o_busy        = (r_state != StLoadA);
    assign o_pair_count  = r_pair_count;
    assign o_timeout_err = r_timeout_err;

    always_comb begin
        w_state_next = r_state;
        w_tmo_expire = 1'b0;
        unique case (r_state)
            StLoadA: begin
                if (w_xfer) w_state_next = StLoadB;
            end
            StLoadB: begin
                if (w_xfer) begin
                    w_state_next = StIssue;
                end else if (TmoEn && (r_tmo == TmoLast)) begin
                    w_state_next = StLoadA;
                    w_tmo_expire = 1'b1;
                end
            end
            StIssue: begin
                if (r_hold == 4'd0) w_state_next = StLoadA;
            end
            default: w_state_next = StLoadA;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StLoadA;
            r_a           <= '0;
            r_b           <= '0;
            r_hold        <= '0;
            r_pair_count  <= '0;
            r_tmo         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timeout_err <= w_tmo_expire;
            if ((r_state == StLoadA) && w_xfer) r_a <= bus.in_data;
            if ((r_state == StLoadB) && w_xfer) begin
                r_b    <= bus.in_data;
                r_hold <= HoldLast;
            end
            if (r_state == StIssue) begin
                if (r_hold == 4'd0) r_pair_count <= r_pair_count + 4'd1;
                else                r_hold       <= r_hold - 4'd1;
            end
            // Counter is zero whenever LOAD_B is entered because it clears outside LOAD_B.
            if (!TmoEn || (r_state != StLoadB)) r_tmo <= '0;
            else if (!w_xfer)                   r_tmo <= r_tmo + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomized bench for alu_operand_loader against a transaction-level model of pairing and issue.
module tb_alu_operand_loader;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned HOLD    = 2;
    localparam int unsigned TIMEOUT = 8;
`ifdef ALU_OPERAND_LOADER_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [3:0] pair_count;
    logic       timeout_err;

    alu_operand_loader_if #(.WIDTH(WIDTH)) bus ();

    alu_operand_loader #(
        .WIDTH   (WIDTH),
        .HOLD    (HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus),
        .o_busy        (busy),
        .o_pair_count  (pair_count),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: operands seen, whether half a pair is pending, en cycles left, idle wait in LOAD_B.
    int m_a, m_b, m_cnt, m_left, m_wait;
    bit m_have_a, m_err;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit xfer;
        xfer  = bus.in_valid && (m_left == 0);
        m_err = 1'b0;
        if (rst) begin
            m_a = 0; m_b = 0; m_cnt = 0; m_left = 0; m_wait = 0; m_have_a = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_cnt = (m_cnt + 1) % 16;
        end else if (xfer) begin
            if (!m_have_a) begin
                m_a = int'(bus.in_data); m_have_a = 1'b1; m_wait = 0;
            end else begin
                m_b = int'(bus.in_data); m_have_a = 1'b0; m_left = HOLD;
            end
        end else if (m_have_a && TmoEn) begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
                m_have_a = 1'b0;
                m_err    = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("a",           int'(bus.a),        m_a);
        check_eq("b",           int'(bus.b),        m_b);
        check_eq("en",          int'(bus.en),       int'(m_left > 0));
        check_eq("in_ready",    int'(bus.in_ready), int'(m_left == 0));
        check_eq("busy",        int'(busy),         int'(m_have_a || (m_left > 0)));
        check_eq("pair_count",  int'(pair_count),   m_cnt);
        check_eq("timeout_err", int'(timeout_err),  int'(m_err));
    endtask

    // One clock: model consumes the inputs the DUT saw at the edge, outputs checked at negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Upstream holds a stalled word; otherwise draws new stimulus.
    task automatic drive(input int valid_pct, input int rst_pct);
        if (!(bus.in_valid && (m_left != 0))) begin
            bus.in_valid = ($urandom_range(0, 99) < valid_pct);
            bus.in_data  = 4'($urandom_range(0, 15));
        end
        rst = ($urandom_range(0, 99) < rst_pct);
    endtask

    initial begin
        m_a = 0; m_b = 0; m_cnt = 0; m_left = 0; m_wait = 0; m_have_a = 1'b0; m_err = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1111;
        repeat (2) cycle();
        rst = 1'b0;

        // Directed back-to-back pair then a word held through ISSUE.
        bus.in_data = 4'b0011;
        cycle();
        bus.in_data = 4'b1110;
        cycle();
        bus.in_data = 4'b0101;
        repeat (HOLD + 2) cycle();
        bus.in_valid = 1'b0;
        repeat (3) cycle();

        // Dense traffic: many pairs, so pair_count wraps several times.
        for (int i = 0; i < 800; i++) begin
            drive(90, 0);
            cycle();
        end
        // Dense traffic with occasional resets landing in every state.
        for (int i = 0; i < 600; i++) begin
            drive(80, 3);
            cycle();
        end
        rst = 1'b0;
        // Sparse traffic: long LOAD_B waits exercise the abort timer when enabled.
        for (int i = 0; i < 800; i++) begin
            drive(8, 0);
            cycle();
        end
        // Long idle wait in LOAD_B after one word.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1010;
        while (m_left != 0 || m_have_a) cycle();
        cycle();
        bus.in_valid = 1'b0;
        repeat (TIMEOUT + 6) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
